// File: rtl/asteroid_pkg.sv
// Shared types, defaults and helpers for the asteroid spawner slice.
package asteroid_pkg;

    localparam int unsigned COLS_DEFAULT     = 16;
    localparam int unsigned BASE_GAP_DEFAULT = 4;

    typedef logic [1:0] level_t;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        PENDING
    } spawn_state_t;

    // Number of asteroids in a row; a built row never holds more than two.
    function automatic logic [1:0] popcount2(input logic [15:0] row);
        logic [1:0] n;
        n = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (row[i] && (n != 2'd2)) begin
                n = n + 2'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/asteroid_spawner_if.sv
// Row handshake between the spawner (master) and the field shifter (slave).
interface asteroid_spawner_if #(
    parameter int unsigned COLS = asteroid_pkg::COLS_DEFAULT
);

    logic            spawn_valid;
    logic            spawn_ready;
    logic [COLS-1:0] spawn_row;

    modport master (
        output spawn_valid,
        output spawn_row,
        input  spawn_ready
    );

    modport slave (
        input  spawn_valid,
        input  spawn_row,
        output spawn_ready
    );

endinterface

// File: rtl/asteroid_spawner_cooldown.sv
// Spawn cooldown down-counter: load, decrement, and a flag that the
// current value is the last one before expiry.
module spawn_cooldown
#(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned RESET_VAL = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero_next
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load has priority over decrement; never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= WIDTH'(RESET_VAL);
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_next = (count_q == WIDTH'(1));

endmodule

// File: rtl/asteroid_spawner.sv
// Builds a new asteroid row from the LFSR word every R game ticks and
// offers it downstream over a valid/ready handshake.
module asteroid_spawner
    import asteroid_pkg::*;
#(
    parameter int unsigned COLS     = COLS_DEFAULT,
    parameter int unsigned BASE_GAP = BASE_GAP_DEFAULT
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [9:0]         rnd,
    input  logic               tick,
    input  logic               enable,
    input  level_t             level,
    asteroid_spawner_if.master spawn,
    output logic [7:0]         spawn_total
);

    localparam int unsigned CIW = $clog2(COLS);
    localparam int unsigned CW  = $clog2(BASE_GAP + 1);

    spawn_state_t    state_q, state_d;
    logic            valid_q, valid_d;
    logic [COLS-1:0] row_q, row_d;
    logic [7:0]      total_q, total_d;
    logic [8:0]      total_sum;
    logic [CW-1:0]   reload_val;
    logic            cd_load;
    logic            cd_dec;
    logic            cd_expire;
    logic            rnd_unused;

    // One column from the low nibble; level 3 may add a second column.
    function automatic logic [COLS-1:0] build_row(input logic [9:0] r, input level_t lv);
        logic [CIW-1:0]  c0;
        logic [CIW-1:0]  c1;
        logic [COLS-1:0] row;
        c0      = r[CIW-1:0];
        c1      = r[4 +: CIW];
        row     = '0;
        row[c0] = 1'b1;
        if ((lv == 2'd3) && r[9] && (c1 != c0)) begin
            row[c1] = 1'b1;
        end
        return row;
    endfunction

    assign reload_val = CW'(BASE_GAP - 32'(level));
    assign total_sum  = {1'b0, total_q} + {7'b0, popcount2(16'(row_q))};
    assign rnd_unused = ^rnd;

    spawn_cooldown #(
        .WIDTH     (CW),
        .RESET_VAL (BASE_GAP)
    ) u_cooldown (
        .CLK       (CLK),
        .RST       (RST),
        .load      (cd_load),
        .dec       (cd_dec),
        .load_val  (reload_val),
        .zero_next (cd_expire)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dropping enable always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = COUNT;
                COUNT:   if (tick && cd_expire) state_d = PENDING;
                PENDING: if (valid_q && spawn.spawn_ready) state_d = COUNT;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath controls: cooldown, row capture, acceptance and running total.
    always_comb begin
        valid_d = valid_q;
        row_d   = row_q;
        total_d = total_q;
        cd_load = 1'b0;
        cd_dec  = 1'b0;
        if (!enable) begin
            valid_d = 1'b0;
            row_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cd_load = 1'b1;
                end
                COUNT: begin
                    if (tick) begin
                        if (cd_expire) begin
                            row_d   = build_row(rnd, level);
                            valid_d = 1'b1;
                            cd_load = 1'b1;
                        end else begin
                            cd_dec = 1'b1;
                        end
                    end
                end
                PENDING: begin
                    if (valid_q && spawn.spawn_ready) begin
                        valid_d = 1'b0;
                        row_d   = '0;
                        total_d = total_sum[8] ? 8'hFF : total_sum[7:0];
                    end
                end
                default: begin
                    valid_d = 1'b0;
                    row_d   = '0;
                end
            endcase
        end
    end

    // Output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= 1'b0;
            row_q   <= '0;
            total_q <= '0;
        end else begin
            valid_q <= valid_d;
            row_q   <= row_d;
            total_q <= total_d;
        end
    end

    assign spawn.spawn_valid = valid_q;
    assign spawn.spawn_row   = row_q;
    assign spawn_total       = total_q;

endmodule

// File: tb/tb_asteroid_spawner.sv
// Self-checking bench for asteroid_spawner: directed table, corner-case
// sequences and randomized traffic against a behavioural model.
module tb_asteroid_spawner;

    localparam int unsigned COLS     = 16;
    localparam int unsigned BASE_GAP = 4;

    logic       CLK;
    logic       RST;
    logic [9:0] rnd;
    logic       tick;
    logic       enable;
    logic [1:0] level;
    logic [7:0] spawn_total;

    asteroid_spawner_if #(.COLS(COLS)) sif ();

    asteroid_spawner #(
        .COLS     (COLS),
        .BASE_GAP (BASE_GAP)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .rnd         (rnd),
        .tick        (tick),
        .enable      (enable),
        .level       (level),
        .spawn       (sif.master),
        .spawn_total (spawn_total)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: running flag, ticks left, pending row, total.
    bit        m_run;
    int        m_cd;
    bit        m_pend;
    bit [15:0] m_row;
    int        m_total;

    typedef struct {
        bit        en;
        bit        t;
        bit        rd;
        bit [1:0]  lv;
        bit [9:0]  r;
        bit        ev;
        bit [15:0] erow;
        int        etot;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit [15:0] exp_row(input bit [9:0] r, input bit [1:0] lv);
        int        c0;
        int        c1;
        bit [15:0] row;
        c0  = int'(r) % COLS;
        c1  = (int'(r) / 16) % COLS;
        row = 16'd1 << c0;
        if (lv == 2'd3 && int'(r) >= 512 && c1 != c0) row = row | (16'd1 << c1);
        return row;
    endfunction

    function automatic int count_bits(input bit [15:0] v);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic model_reset();
        m_run = 0; m_cd = BASE_GAP; m_pend = 0; m_row = '0; m_total = 0;
    endtask

    task automatic model_step(input bit en, input bit t, input bit rd,
                              input bit [1:0] lv, input bit [9:0] r);
        if (!en) begin
            m_run = 0; m_pend = 0; m_row = '0;
        end else if (!m_run) begin
            m_run = 1; m_cd = BASE_GAP - int'(lv);
        end else if (m_pend) begin
            if (rd) begin
                m_total = m_total + count_bits(m_row);
                if (m_total > 255) m_total = 255;
                m_pend = 0; m_row = '0;
            end
        end else if (t) begin
            if (m_cd == 1) begin
                m_row = exp_row(r, lv); m_pend = 1; m_cd = BASE_GAP - int'(lv);
            end else begin
                m_cd = m_cd - 1;
            end
        end
    endtask

    task automatic step(input bit en, input bit t, input bit rd,
                        input bit [1:0] lv, input bit [9:0] r);
        enable = en; tick = t; sif.spawn_ready = rd; level = lv; rnd = r;
        model_step(en, t, rd, lv, r);
        @(posedge CLK);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_valid"}, int'(sif.spawn_valid), int'(m_pend));
        check({tag, "_row"},   int'(sif.spawn_row),   int'(m_row));
        check({tag, "_total"}, int'(spawn_total),     m_total);
    endtask

    initial begin
        int n;

        // en t rd lv rnd | valid row total
        vecs[0]  = '{1, 0, 0, 0, 10'h000, 0, 16'h0000, 0};
        vecs[1]  = '{1, 1, 0, 0, 10'h000, 0, 16'h0000, 0};
        vecs[2]  = '{1, 0, 0, 0, 10'h000, 0, 16'h0000, 0};
        vecs[3]  = '{1, 1, 0, 0, 10'h000, 0, 16'h0000, 0};
        vecs[4]  = '{1, 1, 0, 0, 10'h000, 0, 16'h0000, 0};
        vecs[5]  = '{1, 1, 0, 0, 10'h005, 1, 16'h0020, 0};
        vecs[6]  = '{1, 0, 1, 0, 10'h005, 0, 16'h0000, 1};
        vecs[7]  = '{1, 1, 1, 3, 10'h235, 0, 16'h0000, 1};
        vecs[8]  = '{1, 1, 1, 3, 10'h235, 0, 16'h0000, 1};
        vecs[9]  = '{1, 1, 1, 3, 10'h235, 0, 16'h0000, 1};
        vecs[10] = '{1, 1, 1, 3, 10'h235, 1, 16'h0028, 1};
        vecs[11] = '{1, 1, 1, 3, 10'h235, 0, 16'h0000, 3};
        vecs[12] = '{1, 1, 1, 3, 10'h235, 1, 16'h0028, 3};
        vecs[13] = '{1, 1, 1, 3, 10'h255, 0, 16'h0000, 5};
        vecs[14] = '{1, 1, 1, 3, 10'h255, 1, 16'h0020, 5};
        vecs[15] = '{1, 0, 1, 3, 10'h255, 0, 16'h0000, 6};

        RST = 1'b1; enable = 1'b0; tick = 1'b0; level = 2'd0; rnd = '0;
        sif.spawn_ready = 1'b0;
        model_reset();
        #2;
        check("reset_valid", int'(sif.spawn_valid), 0);
        check("reset_row",   int'(sif.spawn_row),   0);
        check("reset_total", int'(spawn_total),     0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Directed table: base spawn, double rows, c0==c1 single row.
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].en, vecs[i].t, vecs[i].rd, vecs[i].lv, vecs[i].r);
            check($sformatf("tbl%0d_valid", i), int'(sif.spawn_valid), int'(vecs[i].ev));
            check($sformatf("tbl%0d_row", i),   int'(sif.spawn_row),   int'(vecs[i].erow));
            check($sformatf("tbl%0d_total", i), int'(spawn_total),     vecs[i].etot);
        end

        // Backpressure: row held through 10 ticks, then a full R=3 gap.
        step(1, 1, 0, 2'd1, 10'h005);
        check_model("hold_spawn");
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 2'd1, 10'($urandom));
            check_model("hold");
            check("hold_row_const", int'(sif.spawn_row), 32'h0020);
        end
        step(1, 1, 1, 2'd1, 10'h005);
        check_model("hold_accept");
        n = 0;
        while (n < 8 && !sif.spawn_valid) begin
            step(1, 1, 0, 2'd1, 10'h005);
            check_model("hold_gap");
            n++;
        end
        check("gap_after_hold", n, 3);

        // Enable drop while pending discards the row; re-enable gives R=2.
        step(0, 1, 1, 2'd1, 10'h005);
        check_model("drop");
        check("drop_total", int'(spawn_total), 7);
        step(1, 0, 0, 2'd2, 10'h00A);
        check_model("reen");
        n = 0;
        while (n < 8 && !sif.spawn_valid) begin
            step(1, 1, 0, 2'd2, 10'h00A);
            check_model("reen_gap");
            n++;
        end
        check("gap_after_reenable", n, 2);

        // Asynchronous reset mid-run with a row pending and total 7.
        check("pre_rst_valid", int'(sif.spawn_valid), 1);
        check("pre_rst_total", int'(spawn_total), 7);
        RST = 1'b1;
        #1;
        check("async_rst_valid", int'(sif.spawn_valid), 0);
        check("async_rst_row",   int'(sif.spawn_row),   0);
        check("async_rst_total", int'(spawn_total),     0);
        model_reset();
        RST = 1'b0;

        // 130 double spawns saturate the total at 255.
        step(1, 0, 1, 2'd3, 10'h235);
        for (int i = 0; i < 260; i++) begin
            step(1, 1, 1, 2'd3, 10'h235);
            check_model("sat");
        end
        check("saturated_total", int'(spawn_total), 255);

        // Randomized traffic against the model.
        @(negedge CLK);
        RST = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 24) != 0, 1'($urandom), 1'($urandom),
                 2'($urandom), 10'($urandom));
            check_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
